// File: rtl/uart_tx_core.sv
// ---------------------------------------------------------------------------
// uart_tx_core
//
// Serial transmit engine that sits behind the UART APB register block.
// A one-cycle start request launches a frame. The byte is captured on the
// following cycle. The frame goes out on TxD as a start bit, then 5-8 data
// bits LSB first, then an optional parity bit, then 1-2 stop bits. A
// one-cycle TxDone pulse tells the register block to pop its next FIFO entry.
//
// Build option:
//   UART_TX_PARITY_EN  defined   -> PARITY state and parity generator built
//                      undefined -> PEN/EPS ignored, frames never carry parity
//
// Parameters:
//   OVERSAMPLE  PCLK ticks per baud-divider tick (bit = OVERSAMPLE*(UBRR+1))
//   UBRR_W      width of the baud divisor
//
// Ports:
//   PCLK     in   clock, all logic on the rising edge
//   PRESETn  in   asynchronous active-low reset
//   TxEn     in   transmitter enable; low forces the line idle and aborts
//   TxStart  in   one-cycle start request
//   TxData   in   frame byte, valid the cycle after TxStart
//   UBRR     in   baud divisor
//   DLS      in   data length select (0..3 -> 5..8 bits)
//   STOP     in   0 = one stop bit, 1 = two stop bits
//   PEN      in   parity enable
//   EPS      in   1 = even parity, 0 = odd parity
//   TxD      out  registered serial line, idle high
//   TxBusy   out  high from LOAD through the final stop bit
//   TxDone   out  one-cycle pulse when a frame completes normally
// ---------------------------------------------------------------------------
module uart_tx_core #(
  parameter int OVERSAMPLE = 16,
  parameter int UBRR_W     = 12
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              TxEn,
  input  logic              TxStart,
  input  logic [7:0]        TxData,
  input  logic [UBRR_W-1:0] UBRR,
  input  logic [1:0]        DLS,
  input  logic              STOP,
  input  logic              PEN,
  input  logic              EPS,
  output logic              TxD,
  output logic              TxBusy,
  output logic              TxDone
);

  localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0] OS_MAX = OS_W'(OVERSAMPLE - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif
  localparam logic [2:0] STOP1  = 3'd5;
  localparam logic [2:0] STOP2  = 3'd6;

  logic [2:0]        state;
  logic [UBRR_W-1:0] div_cnt;
  logic [OS_W-1:0]   os_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_q;
  logic [UBRR_W-1:0] ubrr_q;
  logic [1:0]        dls_q;
  logic              stop_q;
  logic              txd_q;
  logic              done_q;
  logic              bit_end;
  logic [2:0]        last_bit;

  // A bit period ends when the divider and the oversample counter both wrap.
  assign bit_end  = (div_cnt == ubrr_q) && (os_cnt == OS_MAX);
  assign last_bit = {1'b0, dls_q} + 3'd4;

  assign TxD    = txd_q;
  assign TxDone = done_q;
  assign TxBusy = (state != IDLE);

`ifdef UART_TX_PARITY_EN
  // Parity is computed once from the masked byte at LOAD. It is then only
  // replayed in the PARITY state, so mid-frame PEN/EPS changes cannot leak in.
  logic [7:0] len_mask;
  logic       par_en_q;
  logic       par_bit_q;

  always_comb begin
    len_mask = 8'hFF;
    case (DLS)
      2'd0:    len_mask = 8'h1F;
      2'd1:    len_mask = 8'h3F;
      2'd2:    len_mask = 8'h7F;
      default: len_mask = 8'hFF;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (TxEn && (state == LOAD)) begin
      par_en_q  <= PEN;
      par_bit_q <= (^(TxData & len_mask)) ^ ~EPS;
    end
  end
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = PEN ^ EPS;
`endif

  // Main sequencer. LOAD latches the whole frame configuration and clears the
  // baud counters, so every bit of the frame is exactly one full bit time.
  // TxD is registered and always loaded with the value of the next bit at a
  // bit boundary.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
      div_cnt <= '0;
      os_cnt  <= '0;
      bit_cnt <= '0;
      shift_q <= '0;
      ubrr_q  <= '0;
      dls_q   <= '0;
      stop_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!TxEn) begin
        state <= IDLE;
        txd_q <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            txd_q <= 1'b1;
            if (TxStart) state <= LOAD;
          end
          LOAD: begin
            shift_q <= TxData;
            ubrr_q  <= UBRR;
            dls_q   <= DLS;
            stop_q  <= STOP;
            div_cnt <= '0;
            os_cnt  <= '0;
            bit_cnt <= '0;
            txd_q   <= 1'b0;
            state   <= START;
          end
          default: begin
            if (div_cnt == ubrr_q) begin
              div_cnt <= '0;
              os_cnt  <= (os_cnt == OS_MAX) ? '0 : os_cnt + OS_W'(1);
            end else begin
              div_cnt <= div_cnt + UBRR_W'(1);
            end
            if (bit_end) begin
              case (state)
                START: begin
                  txd_q   <= shift_q[0];
                  shift_q <= {1'b0, shift_q[7:1]};
                  bit_cnt <= '0;
                  state   <= DATA;
                end
                DATA: begin
                  if (bit_cnt == last_bit) begin
`ifdef UART_TX_PARITY_EN
                    if (par_en_q) begin
                      txd_q <= par_bit_q;
                      state <= PARITY;
                    end else begin
                      txd_q <= 1'b1;
                      state <= STOP1;
                    end
`else
                    txd_q <= 1'b1;
                    state <= STOP1;
`endif
                  end else begin
                    txd_q   <= shift_q[0];
                    shift_q <= {1'b0, shift_q[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                  end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                  txd_q <= 1'b1;
                  state <= STOP1;
                end
`endif
                STOP1: begin
                  txd_q <= 1'b1;
                  if (stop_q) begin
                    state <= STOP2;
                  end else begin
                    state  <= IDLE;
                    done_q <= 1'b1;
                  end
                end
                STOP2: begin
                  txd_q  <= 1'b1;
                  state  <= IDLE;
                  done_q <= 1'b1;
                end
                default: begin
                  txd_q <= 1'b1;
                  state <= IDLE;
                end
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule
